// File: rtl/keypad_code_entry.sv
// Keypad PIN collector for the parking gate. Collects BCD digits after a
// vehicle arrives, supports backspace, clear and an inactivity timeout, and
// presents the completed packed code word with a one-cycle acknowledge.
module keypad_code_entry #(
    parameter int DIGITS         = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 3,
    localparam int CODE_W        = 4 * DIGITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vehicle_arrival,
    input  logic              vehicle_left,
    input  logic              key_valid,
    input  logic [3:0]        key_value,
    output logic [CODE_W-1:0] code,
    output logic              code_ack,
    output logic [CNT_W-1:0]  digit_count,
    output logic              entry_timeout,
    output logic              busy
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_HOLD    = 2'd2;

    // The expiry test fires on the idle cycle that brings the idle run to
    // TIMEOUT_CYCLES-1, so it compares against the value one below that.
    localparam logic [15:0]      TMO_LAST = 16'(TIMEOUT_CYCLES - 2);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DIGITS - 1);

    logic [1:0]        state_q, state_d;
    logic [CODE_W-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [15:0]       timer_q, timer_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              ack_q, ack_d;
    logic              tmo_q, tmo_d;

    logic              key_digit;
    logic              key_bksp;
    logic              key_clr;
    logic [CODE_W-1:0] sreg_shifted;

    // Key classification and the shift-in of the current key into the buffer
    always_comb begin
        key_digit    = key_valid && (key_value <= 4'd9);
        key_bksp     = key_valid && (key_value == 4'hB);
        key_clr      = key_valid && (key_value == 4'hC);
        sreg_shifted = (sreg_q << 4) | CODE_W'(key_value);
    end

    // Next-state logic: vehicle_left beats arrival, arrival beats keys,
    // and an applied key beats timer expiry
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        count_d = count_q;
        timer_d = timer_q;
        code_d  = code_q;
        ack_d   = 1'b0;
        tmo_d   = 1'b0;

        if (vehicle_left) begin
            state_d = S_IDLE;
            sreg_d  = '0;
            count_d = '0;
            timer_d = '0;
        end else if (vehicle_arrival) begin
            state_d = S_COLLECT;
            sreg_d  = '0;
            count_d = '0;
            timer_d = '0;
        end else begin
            case (state_q)
                S_COLLECT: begin
                    if (key_digit) begin
                        timer_d = '0;
                        if (count_q == LAST_IDX) begin
                            code_d  = sreg_shifted;
                            ack_d   = 1'b1;
                            sreg_d  = '0;
                            count_d = '0;
                            state_d = S_HOLD;
                        end else begin
                            sreg_d  = sreg_shifted;
                            count_d = count_q + CNT_W'(1);
                        end
                    end else if (key_bksp && (count_q != '0)) begin
                        sreg_d  = sreg_q >> 4;
                        count_d = count_q - CNT_W'(1);
                        timer_d = '0;
                    end else if (key_clr) begin
                        sreg_d  = '0;
                        count_d = '0;
                        timer_d = '0;
                    end else if (timer_q == TMO_LAST) begin
                        // Abandon the entry; the last completed code stays visible
                        tmo_d   = 1'b1;
                        state_d = S_IDLE;
                        sreg_d  = '0;
                        count_d = '0;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 16'd1;
                    end
                end
                S_HOLD: begin
                    // A fresh digit starts a retry with that digit already buffered
                    if (key_digit) begin
                        state_d = S_COLLECT;
                        sreg_d  = CODE_W'(key_value);
                        count_d = CNT_W'(1);
                        timer_d = '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            sreg_q  <= '0;
            count_q <= '0;
            timer_q <= '0;
            code_q  <= '0;
            ack_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            count_q <= count_d;
            timer_q <= timer_d;
            code_q  <= code_d;
            ack_q   <= ack_d;
            tmo_q   <= tmo_d;
        end
    end

    assign code          = code_q;
    assign code_ack      = ack_q;
    assign digit_count   = count_q;
    assign entry_timeout = tmo_q;
    assign busy          = (state_q == S_COLLECT);

endmodule

// File: tb/tb_keypad_code_entry.sv
// Bench for keypad_code_entry: a queue-based model of the PIN session checked
// every cycle, plus hand-computed literal expectations for the directed cases.
module tb_keypad_code_entry;

    localparam int DIGITS = 4;
    localparam int TMO    = 20;
    localparam int CNT_W  = 3;

    logic        clk;
    logic        rst;
    logic        vehicle_arrival;
    logic        vehicle_left;
    logic        key_valid;
    logic [3:0]  key_value;
    logic [15:0] code;
    logic        code_ack;
    logic [2:0]  digit_count;
    logic        entry_timeout;
    logic        busy;

    keypad_code_entry #(
        .DIGITS(DIGITS),
        .TIMEOUT_CYCLES(TMO),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .vehicle_arrival(vehicle_arrival),
        .vehicle_left(vehicle_left),
        .key_valid(key_valid),
        .key_value(key_value),
        .code(code),
        .code_ack(code_ack),
        .digit_count(digit_count),
        .entry_timeout(entry_timeout),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Model: mode 0 = idle, 1 = collecting, 2 = holding a completed code
    int          mq[$];
    int          mmode;
    int          midle;
    logic [15:0] e_code;
    logic        e_ack;
    logic        e_tmo;
    logic        e_busy;
    logic [2:0]  e_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [15:0] pack_digits();
        int v = 0;
        foreach (mq[i]) v = v * 16 + mq[i];
        return v[15:0];
    endfunction

    task automatic model_outputs();
        e_cnt  = 3'(mq.size());
        e_busy = (mmode == 1);
    endtask

    task automatic model_reset();
        mq.delete();
        mmode  = 0;
        midle  = 0;
        e_code = '0;
        e_ack  = 1'b0;
        e_tmo  = 1'b0;
        model_outputs();
    endtask

    // Predict the outputs after the coming clock edge from the current inputs
    task automatic model_step();
        e_ack = 1'b0;
        e_tmo = 1'b0;
        if (!rst) begin
            model_reset();
        end else if (vehicle_left) begin
            mq.delete(); mmode = 0; midle = 0;
        end else if (vehicle_arrival) begin
            mq.delete(); mmode = 1; midle = 0;
        end else if (mmode == 1) begin
            if (key_valid && key_value <= 4'd9) begin
                mq.push_back(int'(key_value));
                midle = 0;
                if (mq.size() == DIGITS) begin
                    e_code = pack_digits();
                    e_ack  = 1'b1;
                    mq.delete();
                    mmode = 2;
                end
            end else if (key_valid && key_value == 4'hB && mq.size() > 0) begin
                void'(mq.pop_back());
                midle = 0;
            end else if (key_valid && key_value == 4'hC) begin
                mq.delete();
                midle = 0;
            end else begin
                midle++;
                if (midle == TMO - 1) begin
                    e_tmo = 1'b1;
                    mmode = 0;
                    mq.delete();
                    midle = 0;
                end
            end
        end else if (mmode == 2 && key_valid && key_value <= 4'd9) begin
            mq.delete();
            mq.push_back(int'(key_value));
            mmode = 1;
            midle = 0;
        end
        model_outputs();
    endtask

    // Per-cycle comparison against the model, 1 time unit after each edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("cyc_code", 32'(code), 32'(e_code));
            chk("cyc_ack", 32'(code_ack), 32'(e_ack));
            chk("cyc_count", 32'(digit_count), 32'(e_cnt));
            chk("cyc_timeout", 32'(entry_timeout), 32'(e_tmo));
            chk("cyc_busy", 32'(busy), 32'(e_busy));
            chk("cyc_ack_tmo_excl", 32'(code_ack & entry_timeout), 32'd0);
        end
    end

    // One clock cycle: drive at the falling edge, return 2 units after the rising edge
    task automatic cyc(input logic arr, input logic lft, input logic kv, input logic [3:0] kval);
        @(negedge clk);
        vehicle_arrival = arr;
        vehicle_left    = lft;
        key_valid       = kv;
        key_value       = kval;
        model_step();
        @(posedge clk);
        #2;
    endtask

    task automatic key(input logic [3:0] k);
        cyc(1'b0, 1'b0, 1'b1, k);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 4'h0);
    endtask

    task automatic arrive();
        cyc(1'b1, 1'b0, 1'b0, 4'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        vehicle_arrival = 1'b0;
        vehicle_left = 1'b0;
        key_valid = 1'b0;
        key_value = 4'h0;
        model_reset();
        idle(3);
        chk("reset_code", 32'(code), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_count", 32'(digit_count), 32'h0);
        rst = 1'b1;
        idle(2);

        // Case 1: plain four-digit entry
        arrive();
        chk("t1_busy_after_arrival", 32'(busy), 32'h1);
        key(4'h1); key(4'h5); key(4'h9); key(4'h9);
        chk("t1_code", 32'(code), 32'h1599);
        chk("t1_ack", 32'(code_ack), 32'h1);
        chk("t1_busy", 32'(busy), 32'h0);
        chk("t1_count", 32'(digit_count), 32'h0);
        idle(1);
        chk("t1_ack_single", 32'(code_ack), 32'h0);
        chk("t1_code_held", 32'(code), 32'h1599);

        // Case 5a: retry from hold
        key(4'h2);
        chk("t5_retry_count", 32'(digit_count), 32'h1);
        chk("t5_retry_busy", 32'(busy), 32'h1);
        key(4'h2); key(4'h2); key(4'h2);
        chk("t5_code", 32'(code), 32'h2222);
        chk("t5_ack", 32'(code_ack), 32'h1);
        idle(1);

        // Case 4: inactivity timeout, code retained
        arrive();
        key(4'h3);
        idle(TMO - 2);
        chk("t4_no_tmo_yet", 32'(entry_timeout), 32'h0);
        chk("t4_busy_before", 32'(busy), 32'h1);
        idle(1);
        chk("t4_tmo", 32'(entry_timeout), 32'h1);
        chk("t4_idle", 32'(busy), 32'h0);
        chk("t4_code_kept", 32'(code), 32'h2222);
        chk("t4_no_ack", 32'(code_ack), 32'h0);
        idle(1);
        chk("t4_tmo_single", 32'(entry_timeout), 32'h0);
        // A key on the would-be expiry cycle wins
        arrive();
        key(4'h3);
        idle(TMO - 2);
        key(4'h4);
        chk("t4b_no_tmo", 32'(entry_timeout), 32'h0);
        chk("t4b_count", 32'(digit_count), 32'h2);
        idle(TMO - 2);
        chk("t4b_no_tmo_yet", 32'(entry_timeout), 32'h0);
        idle(1);
        chk("t4b_tmo", 32'(entry_timeout), 32'h1);

        // Case 3: backspace at zero, clear, all-zero PIN
        arrive();
        key(4'hB);
        chk("t3_bksp_zero", 32'(digit_count), 32'h0);
        key(4'h4); key(4'h4);
        chk("t3_count2", 32'(digit_count), 32'h2);
        key(4'hC);
        chk("t3_clear", 32'(digit_count), 32'h0);
        key(4'hA);
        chk("t3_ignored_key", 32'(digit_count), 32'h0);
        key(4'h0); key(4'h0); key(4'h0); key(4'h0);
        chk("t3_code", 32'(code), 32'h0000);
        chk("t3_ack", 32'(code_ack), 32'h1);
        key(4'hB);
        chk("t3_hold_bksp", 32'(busy), 32'h0);

        // Case 2: backspace mid-entry
        arrive();
        key(4'h1); chk("t2_cnt_a", 32'(digit_count), 32'h1);
        key(4'h5); chk("t2_cnt_b", 32'(digit_count), 32'h2);
        key(4'h7); chk("t2_cnt_c", 32'(digit_count), 32'h3);
        key(4'hB); chk("t2_cnt_d", 32'(digit_count), 32'h2);
        key(4'h9); chk("t2_cnt_e", 32'(digit_count), 32'h3);
        chk("t2_no_early_ack", 32'(code_ack), 32'h0);
        key(4'h9); chk("t2_cnt_f", 32'(digit_count), 32'h0);
        chk("t2_code", 32'(code), 32'h1599);
        chk("t2_ack", 32'(code_ack), 32'h1);
        idle(1);

        // Case 5b: vehicle leaves mid-entry
        arrive();
        key(4'h7); key(4'h8);
        cyc(1'b0, 1'b1, 1'b0, 4'h0);
        chk("t5b_busy", 32'(busy), 32'h0);
        chk("t5b_count", 32'(digit_count), 32'h0);
        chk("t5b_no_ack", 32'(code_ack), 32'h0);
        chk("t5b_code_held", 32'(code), 32'h1599);
        key(4'h3);
        chk("t5b_idle_key", 32'(digit_count), 32'h0);

        // Case 6: asynchronous reset between digits
        arrive();
        key(4'h6); key(4'h6);
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        chk("t6_code", 32'(code), 32'h0);
        chk("t6_count", 32'(digit_count), 32'h0);
        chk("t6_busy", 32'(busy), 32'h0);
        chk("t6_ack", 32'(code_ack), 32'h0);
        chk("t6_tmo", 32'(entry_timeout), 32'h0);
        idle(2);
        rst = 1'b1;
        key(4'h3); key(4'h4); key(4'h5); key(4'h6);
        chk("t6_noarr_count", 32'(digit_count), 32'h0);
        chk("t6_noarr_busy", 32'(busy), 32'h0);
        chk("t6_noarr_code", 32'(code), 32'h0);
        idle(2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
